// File: rtl/alarm_match_if.sv
// Signal bundle between the timekeeping/user-control side and the alarm controller.
// The master side drives time, alarm and user requests; the slave side returns alarm status.
interface alarm_match_if #(
    parameter int WIDTH = 13,
    parameter int SNZ_W = 2
);
    logic             tick;
    logic [WIDTH-1:0] time_now;
    logic [WIDTH-1:0] alarm_time;
    logic             alarm_en;
    logic             snooze;
    logic             stop;
    logic             eq;
    logic             ring;
    logic [1:0]       state;
    logic [SNZ_W-1:0] snooze_cnt;

    modport master (
        output tick, time_now, alarm_time, alarm_en, snooze, stop,
        input  eq, ring, state, snooze_cnt
    );

    modport slave (
        input  tick, time_now, alarm_time, alarm_en, snooze, stop,
        output eq, ring, state, snooze_cnt
    );
endinterface

// File: rtl/alarm_match_ctrl.sv
// Alarm time comparator with first-match detection and a ring/snooze/timeout FSM.
//   state   | meaning
//   IDLE    | waiting for an armed first-cycle match
//   RINGING | buzzer on, counting ring ticks
//   SNOOZED | buzzer off, counting snooze ticks
module alarm_match_ctrl #(
    parameter int WIDTH        = 13,
    parameter int RING_TICKS   = 60,
    parameter int SNOOZE_TICKS = 300,
    parameter int MAX_SNOOZE   = 3,
    parameter int CNT_W        = 16
) (
    input logic         clk,
    input logic         rst_n,
    alarm_match_if.slave bus
);
    localparam int SNZ_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_TICKS - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_TICKS - 1);
    localparam logic [SNZ_W-1:0] SNZ_MAX     = SNZ_W'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RINGING = 2'b01,
        SNOOZED = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SNZ_W-1:0] snz_q, snz_d;
    logic             eq_q;
    logic             cmp;
    logic             match_evt;
    logic             ring_o;

    assign cmp       = (bus.time_now == bus.alarm_time);
    assign match_evt = cmp & ~eq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            snz_q   <= '0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snz_q   <= snz_d;
            eq_q    <= cmp;
        end
    end

    // Any state change loads cnt with 0, so a coincident tick is dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snz_d   = snz_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.alarm_en && match_evt) begin
                    state_d = RINGING;
                    snz_d   = '0;
                end
            end
            RINGING: begin
                if (!bus.alarm_en || bus.stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (bus.snooze && (snz_q < SNZ_MAX)) begin
                    state_d = SNOOZED;
                    cnt_d   = '0;
                    snz_d   = snz_q + SNZ_W'(1);
                end else if (bus.tick) begin
                    if (cnt_q == RING_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            SNOOZED: begin
                if (!bus.alarm_en || bus.stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (bus.tick) begin
                    if (cnt_q == SNOOZE_LAST) begin
                        state_d = RINGING;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        ring_o = (state_q == RINGING);
    end

    assign bus.eq         = eq_q;
    assign bus.ring       = ring_o;
    assign bus.state      = state_q;
    assign bus.snooze_cnt = snz_q;
endmodule

// File: doc/alarm_match_ctrl.md
Name: alarm_match_ctrl

Overview:
Parametrised successor to the fixed 13-bit equality comparator used by the alarm clock. It registers the current-time vs alarm-time comparison, detects the first cycle of a match, and runs the alarm ring / snooze / timeout state machine. It sits between the timekeeping counter and the buzzer/LED drivers and is advanced by the 1 Hz tick enable.

Parameters:
WIDTH, 13, bit width of the encoded time and alarm values.
RING_TICKS, 60, ticks the alarm rings before auto-stop (>=1).
SNOOZE_TICKS, 300, ticks spent in snooze before ringing again (>=1).
MAX_SNOOZE, 3, snoozes accepted per alarm event; further snooze requests are ignored (0 disables snooze).
CNT_W, 16, width of the internal tick counter; must hold max(RING_TICKS, SNOOZE_TICKS).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
tick  in  1  one-cycle 1 Hz enable.
time_now  in  WIDTH  current time encoding.
alarm_time  in  WIDTH  programmed alarm time.
alarm_en  in  1  alarm armed; level.
snooze  in  1  snooze request; level, sampled each clk.
stop  in  1  stop request; level, sampled each clk.
eq  out  1  registered (time_now == alarm_time).
ring  out  1  high while in RINGING.
state  out  2  00 IDLE, 01 RINGING, 10 SNOOZED (11 unused).
snooze_cnt  out  clog2(MAX_SNOOZE+1)  snoozes used in the current alarm event.

Behaviour:
- Reset (rst_n=0, asynchronous): eq=0, ring=0, state=IDLE, snooze_cnt=0, tick counter=0. Everything else is registered on the clk rising edge.
- cmp = (time_now == alarm_time), full WIDTH, unsigned; eq <= cmp every clk.
- match_evt = cmp & ~eq. It fires on the first cycle of equality only; a held match does not re-fire.
- All outputs are registered (Moore). ring and state update on the same edge at which eq first rises. Latency from equal inputs to ring=1 is one edge.
- Priority within a cycle, highest first: alarm_en=0, stop, snooze, tick-driven timeout.
- IDLE:
  - alarm_en & match_evt -> RINGING; cnt=0; snooze_cnt=0.
  - match_evt with alarm_en=0 is ignored.
- RINGING (ring=1):
  - alarm_en=0 or stop -> IDLE.
  - snooze with snooze_cnt<MAX_SNOOZE -> SNOOZED; cnt=0; snooze_cnt+1.
  - snooze with snooze_cnt==MAX_SNOOZE is ignored.
  - Otherwise, on tick: if cnt==RING_TICKS-1 -> IDLE, else cnt+1.
- SNOOZED (ring=0):
  - alarm_en=0 or stop -> IDLE.
  - On tick: if cnt==SNOOZE_TICKS-1 -> RINGING with cnt=0, else cnt+1.
  - snooze held here has no effect.
- match_evt while in RINGING or SNOOZED is ignored; the counter and snooze_cnt are not restarted.
- Changing alarm_time mid-ring does not stop the ring.
- On entry to IDLE, cnt=0. snooze_cnt holds its value until the next alarm event starts.
- tick and a transition in the same cycle: the transition wins and cnt loads 0; that tick is not counted.
- The counter never wraps. It is bounded by the terminal compares.
- Reset mid-ring drops ring asynchronously.

Test Plan:
(Bench params: WIDTH=13, RING_TICKS=4, SNOOZE_TICKS=3, MAX_SNOOZE=2; tick every 4 clk.)
1. alarm_en=1, alarm_time=13'h0123, time_now steps 13'h0122 -> 13'h0123 -> eq=1, state=01, ring=1 one edge later. After 4 ticks: state=00, ring=0. time_now held at 13'h0123: no re-trigger.
2. alarm_en=0, time_now==alarm_time=13'h1FFF -> eq=1, ring stays 0, state=00.
3. Ring, then pulse snooze -> state=10, snooze_cnt=1. After 3 ticks: state=01. Snooze again -> snooze_cnt=2. Ring again, snooze a third time -> ignored, state=01, then timeout to 00.
4. Assert stop and snooze in the same cycle while ringing -> state=00, snooze_cnt unchanged. Drop alarm_en while SNOOZED -> state=00 next edge.
5. During RINGING, set time_now != alarm_time, then equal again -> no counter restart: ring ends 4 ticks after the original entry.
6. Drive rst_n=0 asynchronously mid-RINGING (between clk edges) -> ring=0, state=00, eq=0, snooze_cnt=0 immediately. Release with equal inputs -> eq rises and ring=1 on the first edge.
